controle_batalha: RTL

// Round sequencer for the two-player code-battle game. Player A commits a 3-bit code.

---
 rtl/controle_batalha.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/controle_batalha.sv
// Round sequencer for the two-player code battle: A commits a 3-bit code and B must
// answer with its bitwise complement. The block keeps the scores, counts rounds and names the winner.
module controle_batalha #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int RODADAS        = 5,
  parameter int TIMEOUT        = 255,
  parameter int W_PLACAR       = 4,
  localparam int W_TENT = ($clog2(MAX_TENTATIVAS + 1) < 2) ? 2 : $clog2(MAX_TENTATIVAS + 1),
  localparam int W_ROD  = $clog2(RODADAS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          ja,
  input  logic                ja_conf,
  input  logic [2:0]          jb,
  input  logic                jb_conf,
  input  logic                novo_jogo,
  output logic [1:0]          estado,
  output logic                acerto,
  output logic                erro,
  output logic                invalido,
  output logic                estouro,
  output logic [W_TENT-1:0]   tentativas,
  output logic [W_ROD-1:0]    rodada,
  output logic [W_PLACAR-1:0] placar_a,
  output logic [W_PLACAR-1:0] placar_b,
  output logic                fim,
  output logic [1:0]          vencedor
);

  localparam int W_TIMER = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W_TIMER-1:0] TIMER_LAST = W_TIMER'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [W_TENT-1:0]  TENT_MAX   = W_TENT'(MAX_TENTATIVAS);
  localparam logic [W_ROD-1:0]   ROD_LAST   = W_ROD'(RODADAS);

  typedef enum logic [1:0] {
    ESPERA_A  = 2'd0,
    ESPERA_B  = 2'd1,
    RESULTADO = 2'd2,
    FIM       = 2'd3
  } estado_t;

  estado_t             r_estado;
  logic [2:0]          r_segredo;
  logic [W_TENT-1:0]   r_tent;
  logic [W_ROD-1:0]    r_rodada;
  logic [W_PLACAR-1:0] r_placar_a;
  logic [W_PLACAR-1:0] r_placar_b;
  logic [W_TIMER-1:0]  r_timer;
  logic                r_acerto;
  logic                r_erro;
  logic                r_invalido;
  logic                r_estouro;
  logic                r_fim;
  logic [1:0]          r_vencedor;
  logic                r_ja_conf_q;
  logic                r_jb_conf_q;

  estado_t             w_estado;
  logic [2:0]          w_segredo;
  logic [W_TENT-1:0]   w_tent;
  logic [W_ROD-1:0]    w_rodada;
  logic [W_ROD-1:0]    w_rodada_inc;
  logic [W_PLACAR-1:0] w_placar_a;
  logic [W_PLACAR-1:0] w_placar_b;
  logic [W_TIMER-1:0]  w_timer;
  logic                w_acerto;
  logic                w_erro;
  logic                w_invalido;
  logic                w_estouro;
  logic                w_fim;
  logic [1:0]          w_vencedor;
  logic                w_edge_a;
  logic                w_edge_b;
  logic                w_ja_valido;
  logic                w_jb_valido;

  function automatic logic [W_PLACAR-1:0] sat_inc(input logic [W_PLACAR-1:0] v);
    return (v == {W_PLACAR{1'b1}}) ? v : v + W_PLACAR'(1);
  endfunction

  assign w_edge_a     = ja_conf & ~r_ja_conf_q;
  assign w_edge_b     = jb_conf & ~r_jb_conf_q;
  assign w_ja_valido  = (ja != 3'b000) && (ja != 3'b111);
  assign w_jb_valido  = (jb != 3'b000) && (jb != 3'b111);
  assign w_rodada_inc = r_rodada + W_ROD'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ja_conf_q <= 1'b0;
      r_jb_conf_q <= 1'b0;
    end else begin
      r_ja_conf_q <= ja_conf;
      r_jb_conf_q <= jb_conf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= ESPERA_A;
      r_segredo  <= 3'b000;
      r_tent     <= TENT_MAX;
      r_rodada   <= '0;
      r_placar_a <= '0;
      r_placar_b <= '0;
      r_timer    <= '0;
      r_acerto   <= 1'b0;
      r_erro     <= 1'b0;
      r_invalido <= 1'b0;
      r_estouro  <= 1'b0;
      r_fim      <= 1'b0;
      r_vencedor <= 2'b00;
    end else begin
      r_estado   <= w_estado;
      r_segredo  <= w_segredo;
      r_tent     <= w_tent;
      r_rodada   <= w_rodada;
      r_placar_a <= w_placar_a;
      r_placar_b <= w_placar_b;
      r_timer    <= w_timer;
      r_acerto   <= w_acerto;
      r_erro     <= w_erro;
      r_invalido <= w_invalido;
      r_estouro  <= w_estouro;
      r_fim      <= w_fim;
      r_vencedor <= w_vencedor;
    end
  end

  // A restart request overrides everything, including a confirm edge in the same cycle.
  always_comb begin
    w_estado   = r_estado;
    w_segredo  = r_segredo;
    w_tent     = r_tent;
    w_rodada   = r_rodada;
    w_placar_a = r_placar_a;
    w_placar_b = r_placar_b;
    w_timer    = r_timer;
    w_acerto   = 1'b0;
    w_erro     = 1'b0;
    w_invalido = 1'b0;
    w_estouro  = 1'b0;

    if (novo_jogo) begin
      w_estado   = ESPERA_A;
      w_tent     = TENT_MAX;
      w_rodada   = '0;
      w_placar_a = '0;
      w_placar_b = '0;
      w_timer    = '0;
    end else begin
      case (r_estado)
        ESPERA_A: begin
          if (w_edge_a) begin
            if (!w_ja_valido) begin
              w_invalido = 1'b1;
            end else begin
              w_segredo = ja;
              w_estado  = ESPERA_B;
              w_tent    = TENT_MAX;
              w_timer   = '0;
            end
          end
        end

        ESPERA_B: begin
          if (w_edge_b) begin
            if (!w_jb_valido) begin
              w_invalido = 1'b1;
              w_timer    = '0;
            end else if (jb == ~r_segredo) begin
              w_acerto   = 1'b1;
              w_placar_b = sat_inc(r_placar_b);
              w_estado   = RESULTADO;
            end else begin
              w_erro  = 1'b1;
              w_tent  = r_tent - W_TENT'(1);
              w_timer = '0;
              if (r_tent == W_TENT'(1)) begin
                w_placar_a = sat_inc(r_placar_a);
                w_estado   = RESULTADO;
              end
            end
          end else if ((TIMEOUT > 0) && (r_timer == TIMER_LAST)) begin
            w_estouro  = 1'b1;
            w_placar_a = sat_inc(r_placar_a);
            w_estado   = RESULTADO;
          end else begin
            w_timer = r_timer + W_TIMER'(1);
          end
        end

        RESULTADO: begin
          w_rodada = w_rodada_inc;
          w_estado = (w_rodada_inc == ROD_LAST) ? FIM : ESPERA_A;
        end

        default: begin
        end
      endcase
    end

    w_fim      = (w_estado == FIM);
    w_vencedor = 2'b00;
    if (w_estado == FIM) begin
      if (w_placar_a > w_placar_b)      w_vencedor = 2'b01;
      else if (w_placar_b > w_placar_a) w_vencedor = 2'b10;
      else                              w_vencedor = 2'b11;
    end
  end

  assign estado     = r_estado;
  assign acerto     = r_acerto;
  assign erro       = r_erro;
  assign invalido   = r_invalido;
  assign estouro    = r_estouro;
  assign tentativas = r_tent;
  assign rodada     = r_rodada;
  assign placar_a   = r_placar_a;
  assign placar_b   = r_placar_b;
  assign fim        = r_fim;
  assign vencedor   = r_vencedor;

endmodule
